// File: rtl/uart_tx_if.sv
// Request/serial-line bundle between a UART TX client and the uart_tx block.
// The master drives the request and tick; the slave (uart_tx) drives the line and status.
interface uart_tx_if #(
    parameter int unsigned NB_DATA = 8
);
    logic               i_tick;
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_din;
    logic               o_tx;
    logic               o_busy;
    logic               o_tx_done;

    modport master (
        output i_tick, i_tx_start, i_din,
        input  o_tx, o_busy, o_tx_done
    );

    modport slave (
        input  i_tick, i_tx_start, i_din,
        output o_tx, o_busy, o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA bits LSB first, optional parity, stop period.
// Optional parity bit compiled in with macro UART_TX_PARITY_EN.
module uart_tx #(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned NB_TICKCNT = 5,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic     i_clk,
    input  logic     i_reset,
    uart_tx_if.slave bus
);
    localparam int unsigned NB_BITCNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [NB_TICKCNT-1:0] TICK_LAST = NB_TICKCNT'(15);
    localparam logic [NB_TICKCNT-1:0] STOP_LAST = NB_TICKCNT'(SB_TICK - 1);
    localparam logic [NB_BITCNT-1:0]  BIT_LAST  = NB_BITCNT'(NB_DATA - 1);

    if (NB_DATA < 5 || NB_DATA > 9 || PARITY_ODD > 1 || SB_TICK < 16 ||
        (2 ** NB_TICKCNT) < SB_TICK) begin : g_param_check
        $error("uart_tx: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [NB_TICKCNT-1:0] tick_q, tick_d;
    logic [NB_BITCNT-1:0]  bit_q, bit_d;
    logic [NB_DATA-1:0]    shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // State and registered-output update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next state; every non-IDLE state only moves on a tick
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_tx_start) begin
                    state_d  = S_START;
                    tick_d   = '0;
                    shreg_d  = bus.i_din;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^bus.i_din) ^ 1'(PARITY_ODD);
`endif
                end
            end
            S_START: begin
                if (bus.i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        state_d = S_DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + NB_TICKCNT'(1);
                    end
                end
            end
            S_DATA: begin
                if (bus.i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shreg_d = shreg_q >> 1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + NB_BITCNT'(1);
                        end
                    end else begin
                        tick_d = tick_q + NB_TICKCNT'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bus.i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        state_d = S_STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + NB_TICKCNT'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (bus.i_tick) begin
                    if (tick_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + NB_TICKCNT'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // Outputs follow the upcoming state so the line changes on the transition edge
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && (state_d == S_IDLE);
        unique case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, ignored requests, back-to-back frames,
// mid-frame reset and a slow baud tick; parity frames when UART_TX_PARITY_EN is defined.
module tb_uart_tx;
    localparam int unsigned NB_DATA = 8;
    localparam logic        PAR_ODD = 1'b0;
    localparam int          BIT16   = 16;
    localparam int          BIT163  = 16 * 163;

    logic clk = 1'b1;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tick_mode = 0;
    int   div = 0;
    int   sample_idx = 0;
    int   poke_at = 0;

    uart_tx_if #(.NB_DATA(NB_DATA)) bus ();

    uart_tx #(
        .NB_DATA    (NB_DATA),
        .SB_TICK    (16),
        .NB_TICKCNT (5),
        .PARITY_ODD (0)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Baud tick source: tied high, or one tick every 163 clocks
    always @(negedge clk) begin
        if (tick_mode == 0) begin
            bus.i_tick = 1'b1;
        end else if (div == 162) begin
            div = 0;
            bus.i_tick = 1'b1;
        end else begin
            div = div + 1;
            bus.i_tick = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sample_idx++;
        if (poke_at != 0 && sample_idx == poke_at) begin
            bus.i_tx_start = 1'b1;
            bus.i_din      = 8'h0F;
        end else if (poke_at != 0 && sample_idx == poke_at + 1) begin
            bus.i_tx_start = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit hold);
        bus.i_din      = d;
        bus.i_tx_start = 1'b1;
        sample_idx     = 0;
        step();
        if (!hold) bus.i_tx_start = 1'b0;
    endtask

    // Called on the first sample after the request was accepted
    task automatic expect_frame(input string tag, input logic [7:0] data, input int smin,
                                input int smax, input int bitlen, input bit hold_next,
                                input logic [7:0] next_din);
        int n;
        int bad;
        chk({tag, " busy_rise"}, 32'(bus.o_busy), 32'd1);
        if (smin == smax) begin
            bad = 0;
            for (int i = 0; i < smin; i++) begin
                if (bus.o_tx !== 1'b0) bad++;
                step();
            end
            chk({tag, " start_bad_cycles"}, 32'(bad), 32'd0);
        end else begin
            n = 0;
            while (bus.o_tx === 1'b0 && n <= smax) begin
                n++;
                step();
            end
            chk($sformatf("%s start_len_in_range(len=%0d)", tag, n),
                32'(n >= smin && n <= smax), 32'd1);
        end
        for (int k = 0; k < 8; k++) begin
            bad = 0;
            for (int j = 0; j < bitlen; j++) begin
                if (bus.o_tx !== data[k] || bus.o_busy !== 1'b1) bad++;
                step();
            end
            chk($sformatf("%s d%0d_bad_cycles", tag, k), 32'(bad), 32'd0);
        end
`ifdef UART_TX_PARITY_EN
        bad = 0;
        for (int j = 0; j < bitlen; j++) begin
            if (bus.o_tx !== ((^data) ^ PAR_ODD)) bad++;
            step();
        end
        chk({tag, " parity_bad_cycles"}, 32'(bad), 32'd0);
`endif
        bad = 0;
        for (int j = 0; j < bitlen; j++) begin
            if (bus.o_tx !== 1'b1 || bus.o_tx_done !== 1'b0 || bus.o_busy !== 1'b1) bad++;
            step();
        end
        chk({tag, " stop_bad_cycles"}, 32'(bad), 32'd0);
        chk({tag, " done_pulse"}, 32'(bus.o_tx_done), 32'd1);
        chk({tag, " busy_fall"}, 32'(bus.o_busy), 32'd0);
        chk({tag, " idle_line"}, 32'(bus.o_tx), 32'd1);
        if (hold_next) bus.i_din = next_din;
        else           bus.i_tx_start = 1'b0;
        step();
        chk({tag, " done_one_cycle"}, 32'(bus.o_tx_done), 32'd0);
        chk({tag, " line_after"}, 32'(bus.o_tx), hold_next ? 32'd0 : 32'd1);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_tx_done !== 1'b0) bad++;
            step();
        end
        chk({tag, " idle_bad_cycles"}, 32'(bad), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.i_tx_start = 1'b0;
        bus.i_din      = 8'h00;
        repeat (3) step();
        chk("rst tx", 32'(bus.o_tx), 32'd1);
        chk("rst busy", 32'(bus.o_busy), 32'd0);
        chk("rst done", 32'(bus.o_tx_done), 32'd0);
        reset = 1'b0;
        expect_idle("post_rst", 5);

        // 0x55 with tick tied high: 16 clocks per bit, done 160 clocks after busy
        send(8'h55, 1'b0);
        expect_frame("f55", 8'h55, BIT16, BIT16, BIT16, 1'b0, 8'h00);
        expect_idle("f55", 10);

        // Request of 0x0F in the middle of DATA must be ignored
        poke_at = 40;
        send(8'h55, 1'b0);
        expect_frame("ign", 8'h55, BIT16, BIT16, BIT16, 1'b0, 8'h00);
        poke_at = 0;
        expect_idle("ign", 30);

        // Held request: 0x01 then 0x80 with one idle-high clock between
        send(8'h01, 1'b1);
        expect_frame("b2b1", 8'h01, BIT16, BIT16, BIT16, 1'b1, 8'h80);
        expect_frame("b2b2", 8'h80, BIT16, BIT16, BIT16, 1'b0, 8'h00);
        expect_idle("b2b", 10);

        // Reset in the middle of DATA
        send(8'h55, 1'b0);
        repeat (40) step();
        reset = 1'b1;
        step();
        chk("midrst tx", 32'(bus.o_tx), 32'd1);
        chk("midrst busy", 32'(bus.o_busy), 32'd0);
        chk("midrst done", 32'(bus.o_tx_done), 32'd0);
        reset = 1'b0;
        expect_idle("midrst", 200);
        send(8'h3C, 1'b0);
        expect_frame("f3c", 8'h3C, BIT16, BIT16, BIT16, 1'b0, 8'h00);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b0);
        expect_frame("p07", 8'h07, BIT16, BIT16, BIT16, 1'b0, 8'h00);
        send(8'h03, 1'b0);
        expect_frame("p03", 8'h03, BIT16, BIT16, BIT16, 1'b0, 8'h00);
`endif

        // Baud generator MOD=163: 2608 clocks per bit, start bit 2446..2608
        tick_mode = 1;
        repeat (57) step();
        send(8'hA3, 1'b0);
        expect_frame("fa3", 8'hA3, BIT163 - 162, BIT163, BIT163, 1'b0, 8'h00);
        expect_idle("fa3", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter on the TX side of the TP2 UART datapath.
- Serialises one NB_DATA-bit word per request into a standard async frame: start bit, data LSB first, optional parity, stop bit(s).
- Bit timing comes from the 16x oversampling tick supplied by the baud-rate generator on the same clock domain.
- The block only counts ticks; it never divides the clock itself.

Parameters:
NB_DATA, 8, data bits per frame (5..9)
SB_TICK, 16, ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
NB_TICKCNT, 5, width of oversampling tick counter (must hold SB_TICK-1)
PARITY_ODD, 0, parity sense when parity is compiled in (0 even, 1 odd)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_tick  in  1  one-cycle oversampling tick from baud generator (16 per bit)
i_tx_start  in  1  transmit request, sampled only in IDLE
i_din  in  NB_DATA  word to send, captured on accepted request
o_tx  out  1  serial line, registered, idle high
o_busy  out  1  high from accepted request until return to IDLE
o_tx_done  out  1  one-cycle pulse at end of stop period

Behaviour:
- Clock and reset: one clock i_clk; i_reset is synchronous and active-high. Reset values: state=IDLE, o_tx=1, o_busy=0, o_tx_done=0, tick counter=0, bit counter=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE:
  - o_tx=1.
  - On i_tx_start=1: capture i_din into shift reg, tick counter=0, go START.
  - o_tx=0 and o_busy=1 on that same edge, so they are visible the cycle after the request.
- Tick handling: all states except IDLE advance only on cycles with i_tick=1. Non-tick cycles hold all state.
- START:
  - o_tx=0.
  - On a tick with count==15: count=0, bit index=0, go DATA, o_tx=shreg[0].
  - Otherwise count+1.
- DATA:
  - o_tx=shreg[0].
  - On a tick with count==15: count=0, shreg shifted right.
    - If bit index==NB_DATA-1, go PARITY (or STOP), o_tx=parity bit (or 1).
    - Else bit index+1, o_tx=next LSB.
- PARITY:
  - o_tx=registered parity bit.
  - After 16 ticks, go STOP, o_tx=1.
- STOP:
  - o_tx=1.
  - On a tick with count==SB_TICK-1: go IDLE, o_busy=0, o_tx_done=1 for exactly that one following cycle.
- Bit durations:
  - Start-bit duration is 15..16 tick periods, because request phase is asynchronous to i_tick.
  - Every later bit is exactly 16 tick periods.
- i_tx_start while not IDLE: ignored; i_din not re-sampled.
- Back-to-back: a request held high through o_tx_done is accepted in the first IDLE cycle, giving 1 clock of idle-high line between frames.
- Reset mid-frame: next edge forces o_tx=1, IDLE, no o_tx_done pulse.
- i_tick and i_tx_start in the same IDLE cycle: request accepted; that tick is not counted.
- Tick counter wrap: the counter never exceeds SB_TICK-1 or 15; it is cleared on every state change.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - Parity bit = XOR of captured data, XOR PARITY_ODD; computed at capture and held in a register.
  - Frame length = 1+NB_DATA+1+stop.
- Undefined:
  - No PARITY state or parity register; DATA goes directly to STOP.
  - PARITY_ODD is unused.

Test Plan:
- Reset, then i_tick tied high (16 clk/bit), send 0x55 -> o_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles; o_tx_done pulses once, 160 cycles after o_busy rises.
- Generator MOD=163, send 0xA3 -> bit width 2608 clk (start bit 2446..2608), data LSB first 1,1,0,0,0,1,0,1, stop high 2608 clk.
- Pulse i_tx_start with 0x0F during DATA of frame 0x55 -> ignored; line carries only 0x55; single o_tx_done.
- i_tx_start held high, i_din 0x01 then 0x80 -> two consecutive frames with exactly 1 idle-high clock between o_tx_done and the next start bit.
- Assert i_reset in mid DATA -> o_tx=1, o_busy=0 next cycle, no o_tx_done; a new request afterwards sends a full correct frame.
- With UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame is 11 bits.
